// File: rtl/lsu_dmem_master.sv
// Single-outstanding load/store requester for the scratchpad data-memory port, with alignment check and timeout.
// Latency: completion 2 cycles after acceptance with an always-ready/valid memory; misaligned requests complete after 1 cycle.
// Backpressure: core_req_ready only in IDLE; request held stable while dmem_req_ready is low, bounded by TIMEOUT.
module lsu_dmem_master #(
    parameter int TIMEOUT = 16,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        core_req_valid,
    output logic        core_req_ready,
    input  logic        core_req_fcn,
    input  logic [2:0]  core_req_typ,
    input  logic [31:0] core_req_addr,
    input  logic [31:0] core_req_wdata,
    output logic        core_resp_valid,
    output logic [31:0] core_resp_rdata,
    output logic        core_resp_misaligned,
    output logic        core_resp_timeout,
    output logic        dmem_req_valid,
    input  logic        dmem_req_ready,
    output logic [31:0] dmem_req_addr,
    output logic [31:0] dmem_req_data,
    output logic        dmem_req_fcn,
    output logic [2:0]  dmem_req_typ,
    input  logic        dmem_resp_valid,
    input  logic [31:0] dmem_resp_data
);

    typedef enum logic [1:0] {S_IDLE, S_REQ, S_RESP, S_DONE} state_t;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [TW-1:0] r_cnt;
    logic [TW-1:0] w_cnt_inc;
    logic [31:0]   r_addr;
    logic [31:0]   r_data;
    logic [31:0]   r_rdata;
    logic          r_fcn;
    logic [2:0]    r_typ;
    logic          r_mis;
    logic          r_to;
    logic          w_accept;
    logic          w_mis;
    logic          w_capture;
    logic          w_expire;
    logic [31:0]   w_byte_sh;
    logic [31:0]   w_half_sh;
    logic [31:0]   w_ext;

    assign w_accept  = core_req_valid && (r_state == S_IDLE);
    assign w_cnt_inc = r_cnt + 1'b1;
    assign w_expire  = (TIMEOUT != 0) && (w_cnt_inc == TW'(TIMEOUT));
    assign w_capture = dmem_resp_valid &&
                       (((r_state == S_REQ) && dmem_req_ready) || (r_state == S_RESP));

    always_comb begin
        w_mis = 1'b0;
        case (core_req_typ)
            3'd0, 3'd4: w_mis = 1'b0;
            3'd1, 3'd5: w_mis = core_req_addr[0];
            default:    w_mis = |core_req_addr[1:0];
        endcase
    end

    // Lane selection uses the registered address; the response word is always aligned.
    assign w_byte_sh = dmem_resp_data >> {r_addr[1:0], 3'b000};
    assign w_half_sh = dmem_resp_data >> {r_addr[1], 4'b0000};

    always_comb begin
        w_ext = dmem_resp_data;
        case (r_typ)
            3'd0:    w_ext = {{24{w_byte_sh[7]}}, w_byte_sh[7:0]};
            3'd4:    w_ext = {24'd0, w_byte_sh[7:0]};
            3'd1:    w_ext = {{16{w_half_sh[15]}}, w_half_sh[15:0]};
            3'd5:    w_ext = {16'd0, w_half_sh[15:0]};
            default: w_ext = dmem_resp_data;
        endcase
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: if (w_accept) w_state_nxt = w_mis ? S_DONE : S_REQ;
            S_REQ: begin
                if (w_capture || w_expire) w_state_nxt = S_DONE;
                else if (dmem_req_ready)   w_state_nxt = S_RESP;
            end
            S_RESP: if (w_capture || w_expire) w_state_nxt = S_DONE;
            S_DONE: w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_addr  <= '0;
            r_data  <= '0;
            r_fcn   <= 1'b0;
            r_typ   <= '0;
            r_mis   <= 1'b0;
            r_to    <= 1'b0;
            r_rdata <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_accept) begin
                r_cnt   <= '0;
                r_addr  <= core_req_addr;
                r_data  <= core_req_wdata << {core_req_addr[1:0], 3'b000};
                r_fcn   <= core_req_fcn;
                r_typ   <= core_req_typ;
                r_mis   <= w_mis;
                r_to    <= 1'b0;
                r_rdata <= '0;
            end else if ((r_state == S_REQ) || (r_state == S_RESP)) begin
                r_cnt <= w_cnt_inc;
                // A response in the expiry cycle takes priority over the timeout.
                if (w_capture && !r_fcn) r_rdata <= w_ext;
                if (w_expire && !w_capture) r_to <= 1'b1;
            end
        end
    end

    assign core_req_ready       = (r_state == S_IDLE);
    assign dmem_req_valid       = (r_state == S_REQ);
    assign core_resp_valid      = (r_state == S_DONE);
    assign core_resp_rdata      = (r_state == S_DONE) ? r_rdata : 32'd0;
    assign core_resp_misaligned = (r_state == S_DONE) && r_mis;
    assign core_resp_timeout    = (r_state == S_DONE) && r_to;
    assign dmem_req_addr        = r_addr;
    assign dmem_req_data        = r_data;
    assign dmem_req_fcn         = r_fcn;
    assign dmem_req_typ         = r_typ;

endmodule

// File: tb/tb_lsu_dmem_master.sv
// Randomized bench for lsu_dmem_master: two instances (TIMEOUT=16 and TIMEOUT=4) share stimulus,
// a transaction-level model predicts completion cycle, memory request fields and load data.
module tb_lsu_dmem_master;

    logic        clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic        sel;
    logic        core_req_valid;
    logic        core_req_fcn;
    logic [2:0]  core_req_typ;
    logic [31:0] core_req_addr;
    logic [31:0] core_req_wdata;
    logic        dmem_req_ready;
    logic        dmem_resp_valid;
    logic [31:0] dmem_resp_data;

    logic        a_req_ready, a_resp_valid, a_mis, a_to, a_dvalid, a_dfcn;
    logic [31:0] a_rdata, a_daddr, a_ddata;
    logic [2:0]  a_dtyp;
    logic        b_req_ready, b_resp_valid, b_mis, b_to, b_dvalid, b_dfcn;
    logic [31:0] b_rdata, b_daddr, b_ddata;
    logic [2:0]  b_dtyp;
    logic        a_valid_in, b_valid_in;

    assign a_valid_in = core_req_valid & ~sel;
    assign b_valid_in = core_req_valid & sel;

    lsu_dmem_master #(.TIMEOUT(16), .TW(5)) dut (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(a_valid_in), .core_req_ready(a_req_ready),
        .core_req_fcn(core_req_fcn), .core_req_typ(core_req_typ),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_resp_valid(a_resp_valid), .core_resp_rdata(a_rdata),
        .core_resp_misaligned(a_mis), .core_resp_timeout(a_to),
        .dmem_req_valid(a_dvalid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(a_daddr), .dmem_req_data(a_ddata),
        .dmem_req_fcn(a_dfcn), .dmem_req_typ(a_dtyp),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data)
    );

    lsu_dmem_master #(.TIMEOUT(4), .TW(3)) dut_to (
        .clk(clk), .rst_n(rst_n),
        .core_req_valid(b_valid_in), .core_req_ready(b_req_ready),
        .core_req_fcn(core_req_fcn), .core_req_typ(core_req_typ),
        .core_req_addr(core_req_addr), .core_req_wdata(core_req_wdata),
        .core_resp_valid(b_resp_valid), .core_resp_rdata(b_rdata),
        .core_resp_misaligned(b_mis), .core_resp_timeout(b_to),
        .dmem_req_valid(b_dvalid), .dmem_req_ready(dmem_req_ready),
        .dmem_req_addr(b_daddr), .dmem_req_data(b_ddata),
        .dmem_req_fcn(b_dfcn), .dmem_req_typ(b_dtyp),
        .dmem_resp_valid(dmem_resp_valid), .dmem_resp_data(dmem_resp_data)
    );

    logic        m_req_ready, m_resp_valid, m_mis, m_to, m_dvalid, m_dfcn;
    logic [31:0] m_rdata, m_daddr, m_ddata;
    logic [2:0]  m_dtyp;
    assign m_req_ready  = sel ? b_req_ready  : a_req_ready;
    assign m_resp_valid = sel ? b_resp_valid : a_resp_valid;
    assign m_mis        = sel ? b_mis        : a_mis;
    assign m_to         = sel ? b_to         : a_to;
    assign m_dvalid     = sel ? b_dvalid     : a_dvalid;
    assign m_dfcn       = sel ? b_dfcn       : a_dfcn;
    assign m_rdata      = sel ? b_rdata      : a_rdata;
    assign m_daddr      = sel ? b_daddr      : a_daddr;
    assign m_ddata      = sel ? b_ddata      : a_ddata;
    assign m_dtyp       = sel ? b_dtyp       : a_dtyp;

    int checks   = 0;
    int failures = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    function automatic logic is_mis(input logic [2:0] t, input logic [31:0] a);
        int off;
        off = int'(a % 4);
        if (t == 3'd0 || t == 3'd4) return 1'b0;
        if (t == 3'd1 || t == 3'd5) return (off % 2) != 0;
        return off != 0;
    endfunction

    function automatic logic [31:0] load_val(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w);
        int unsigned v;
        int unsigned off;
        off = a % 4;
        case (t)
            3'd0, 3'd4: begin
                v = (w / (32'd1 << (8 * off))) % 256;
                if (t == 3'd0 && v >= 128) v = v + 32'hFFFFFF00;
            end
            3'd1, 3'd5: begin
                v = (w / (32'd1 << (16 * (off / 2)))) % 65536;
                if (t == 3'd1 && v >= 32768) v = v + 32'hFFFF0000;
            end
            default: v = w;
        endcase
        return v;
    endfunction

    task automatic do_txn(input logic f, input logic [2:0] t, input logic [31:0] a,
                          input logic [31:0] wd, input logic [31:0] word,
                          input int d_r, input int d_v);
        int          tmo, h, r, done_c;
        logic        mis, to, vexp;
        logic [31:0] exp_rd, exp_data;
        tmo      = sel ? 4 : 16;
        mis      = is_mis(t, a);
        h        = 1 + d_r;
        r        = (d_v == 0) ? h : h + d_v;
        to       = !mis && (r > tmo);
        done_c   = mis ? 1 : (to ? tmo + 1 : r + 1);
        exp_rd   = (mis || to || f) ? 32'd0 : load_val(t, a, word);
        exp_data = wd * (32'd1 << (8 * (a % 4)));

        @(negedge clk);
        chk("req_ready_idle", 32'(m_req_ready), 32'd1);
        core_req_valid  = 1'b1;
        core_req_fcn    = f;
        core_req_typ    = t;
        core_req_addr   = a;
        core_req_wdata  = wd;
        dmem_req_ready  = 1'b0;
        dmem_resp_valid = 1'b0;
        dmem_resp_data  = $urandom;
        @(posedge clk);
        for (int c = 1; c <= done_c; c++) begin
            @(negedge clk);
            core_req_valid = 1'b0;
            core_req_fcn   = 1'($urandom);
            core_req_typ   = 3'($urandom);
            core_req_addr  = $urandom;
            core_req_wdata = $urandom;
            vexp = !mis && (c <= h) && (c <= tmo);
            chk("dmem_req_valid", 32'(m_dvalid), 32'(vexp));
            if (vexp) begin
                chk("dmem_req_addr", m_daddr, a);
                chk("dmem_req_data", m_ddata, exp_data);
                chk("dmem_req_fcn", 32'(m_dfcn), 32'(f));
                chk("dmem_req_typ", 32'(m_dtyp), 32'(t));
            end
            chk("req_ready_busy", 32'(m_req_ready), 32'd0);
            chk("core_resp_valid", 32'(m_resp_valid), 32'(c == done_c));
            if (c == done_c) begin
                chk("resp_rdata", m_rdata, exp_rd);
                chk("resp_misaligned", 32'(m_mis), 32'(mis));
                chk("resp_timeout", 32'(m_to), 32'(to));
            end
            dmem_req_ready  = (c >= h);
            dmem_resp_valid = (c == r) || ((c == done_c) && ($urandom_range(0, 1) == 1));
            dmem_resp_data  = (c == r) ? word : $urandom;
        end
    endtask

    logic [2:0] typs [8];

    initial begin
        typs = '{3'd0, 3'd1, 3'd3, 3'd4, 3'd5, 3'd2, 3'd6, 3'd7};
        rst_n = 1'b0; sel = 1'b0; core_req_valid = 1'b0; core_req_fcn = 1'b0;
        core_req_typ = '0; core_req_addr = '0; core_req_wdata = '0;
        dmem_req_ready = 1'b0; dmem_resp_valid = 1'b0; dmem_resp_data = '0;
        #2;
        chk("rst_req_ready", 32'(a_req_ready), 32'd1);
        chk("rst_dmem_valid", 32'(a_dvalid), 32'd0);
        chk("rst_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rst_rdata", a_rdata, 32'd0);
        chk("rst_flags", {30'd0, a_mis, a_to}, 32'd0);
        chk("rst_daddr", a_daddr, 32'd0);
        chk("rst_ddata", a_ddata, 32'd0);
        chk("rst_dfcn_typ", {28'd0, a_dfcn, a_dtyp}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // Directed cases from the memory-port scenarios.
        do_txn(1'b0, 3'd0, 32'h1003, 32'd0, 32'h80FF1234, 0, 0);
        do_txn(1'b0, 3'd5, 32'h1002, 32'd0, 32'h80FF1234, 0, 0);
        do_txn(1'b0, 3'd1, 32'h1002, 32'd0, 32'h80FF1234, 0, 0);
        do_txn(1'b0, 3'd3, 32'h1000, 32'd0, 32'h80FF1234, 0, 0);
        do_txn(1'b1, 3'd0, 32'h2001, 32'h000000AB, 32'h55555555, 0, 0);
        do_txn(1'b0, 3'd3, 32'h1002, 32'd0, 32'h80FF1234, 0, 0);
        do_txn(1'b1, 3'd1, 32'h3001, 32'h0000BEEF, 32'h0, 0, 0);
        do_txn(1'b0, 3'd3, 32'h1000, 32'd0, 32'hCAFEF00D, 3, 2);
        sel = 1'b1;
        do_txn(1'b0, 3'd3, 32'h1000, 32'd0, 32'h12345678, 0, 40);
        do_txn(1'b0, 3'd3, 32'h1000, 32'd0, 32'h12345678, 40, 0);
        do_txn(1'b0, 3'd4, 32'h1001, 32'd0, 32'h00C30000, 0, 3);

        for (int i = 0; i < 60; i++) begin
            logic [31:0] ra;
            sel = (i >= 40);
            ra  = $urandom;
            if ($urandom_range(0, 9) < 7) ra[1:0] = ra[1:0] & {typs[i % 8] == 3'd0 || typs[i % 8] == 3'd4, 1'b0};
            do_txn(1'($urandom), typs[$urandom_range(0, 7)], ra, $urandom, $urandom,
                   $urandom_range(0, 3), sel ? $urandom_range(0, 4) : $urandom_range(0, 3));
        end

        // Reset while waiting for a response abandons the transaction.
        sel = 1'b0;
        @(negedge clk);
        core_req_valid = 1'b1; core_req_fcn = 1'b0; core_req_typ = 3'd3;
        core_req_addr = 32'h4000; core_req_wdata = '0;
        dmem_req_ready = 1'b1; dmem_resp_valid = 1'b0;
        @(posedge clk);
        @(negedge clk);
        core_req_valid = 1'b0;
        chk("rstmid_req_valid", 32'(a_dvalid), 32'd1);
        @(negedge clk);
        chk("rstmid_in_resp", 32'(a_dvalid), 32'd0);
        rst_n = 1'b0;
        #1;
        chk("rstmid_ready", 32'(a_req_ready), 32'd1);
        chk("rstmid_resp_valid", 32'(a_resp_valid), 32'd0);
        chk("rstmid_daddr", a_daddr, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        dmem_resp_valid = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            chk("post_rst_resp_valid", 32'(a_resp_valid), 32'd0);
            chk("post_rst_ready", 32'(a_req_ready), 32'd1);
        end
        dmem_resp_valid = 1'b0;
        do_txn(1'b0, 3'd1, 32'h1000, 32'd0, 32'h0000FFFE, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/lsu_dmem_master.md
Name: lsu_dmem_master

Overview:
- Load/store requester that drives the data-memory request/response port of the scratchpad memory (dmem_req_*/dmem_resp_*) on behalf of a multi-cycle core.
- Accepts one core load/store at a time and checks alignment.
- Places store data in the addressed byte lanes, issues the memory request with valid/ready handshake and waits for the response.
- Extracts and sign/zero-extends load data; bounds each transaction with a timeout.

Parameters:
- TIMEOUT, 16, cycles allowed in REQ+RESP before an error completion; 0 disables the timeout.
- TW, 5, width of the timeout counter; must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- core_req_valid  in  1  core request valid
- core_req_ready  out  1  high only in IDLE
- core_req_fcn  in  1  0=load, 1=store
- core_req_typ  in  3  0=B, 1=H, 3=W, 4=BU, 5=HU; other codes treated as W
- core_req_addr  in  32  byte address
- core_req_wdata  in  32  store data, right-justified
- core_resp_valid  out  1  one-cycle completion pulse
- core_resp_rdata  out  32  extended load data; 0 for stores and errors
- core_resp_misaligned  out  1  qualifies core_resp_valid
- core_resp_timeout  out  1  qualifies core_resp_valid
- dmem_req_valid  out  1  memory request valid
- dmem_req_ready  in  1  memory ready
- dmem_req_addr  out  32  registered core address, unmodified
- dmem_req_data  out  32  lane-aligned store data
- dmem_req_fcn  out  1  registered fcn
- dmem_req_typ  out  3  registered typ
- dmem_resp_valid  in  1  memory response valid; may arrive in the same cycle as the handshake (asynchronous memory)
- dmem_resp_data  in  32  full aligned word

Behaviour:
- States: IDLE, REQ, RESP, DONE. All request fields are registered when a request is accepted (core_req_valid & core_req_ready) and stay stable until DONE.
- Reset (async, rst_n=0):
  - State goes to IDLE and the counter clears.
  - Outputs: core_req_ready=1 once in IDLE; dmem_req_valid=0; core_resp_valid=0; core_resp_rdata=0; both flags 0; dmem_req_addr/data/fcn/typ=0.
  - Reset mid-transaction abandons the transaction with no response.
- Alignment check at acceptance:
  - H/HU with addr[0]=1 is misaligned.
  - W with addr[1:0]!=0 is misaligned.
  - A misaligned request goes IDLE->DONE with core_resp_misaligned=1 and never asserts dmem_req_valid.
- IDLE -> REQ on acceptance of an aligned request.
- REQ:
  - dmem_req_valid=1.
  - Store data is shifted left by addr[1:0]*8.
  - When dmem_req_ready=1 the handshake completes. If dmem_resp_valid=1 in the same cycle, capture the response and go to DONE; otherwise go to RESP.
  - While dmem_req_ready=0, valid and all request fields are held unchanged.
- RESP: dmem_req_valid=0; capture the response on the first cycle dmem_resp_valid=1, then go to DONE.
- DONE:
  - core_resp_valid=1 for exactly one cycle, then IDLE.
  - core_req_ready=0 in DONE, so the next request can be accepted in the following cycle at the earliest.
- Load extraction:
  - Select lane = addr[1:0] for byte, addr[1] for half.
  - B/H sign-extend; BU/HU zero-extend; W passes the word unchanged.
- Latency: with a memory that is always ready and always valid, core_resp_valid asserts 2 cycles after the acceptance edge; throughput is 1 transaction per 3 cycles.
- Timeout counter:
  - Cleared on acceptance; increments each cycle in REQ or RESP.
  - When it reaches TIMEOUT (nonzero), go to DONE with core_resp_timeout=1 and rdata=0, and drop dmem_req_valid.
  - A response arriving in the same cycle as the timeout wins: normal completion.
- Never more than one outstanding request; dmem_resp_valid outside REQ/RESP is ignored.

Test Plan:
- LB addr 0x1003, memory word 0x80FF1234 -> dmem_req_typ=0, fcn=0; core_resp_rdata=0xFFFFFF80 two cycles after accept; flags 0.
- LHU addr 0x1002, word 0x80FF1234 -> rdata=0x000080FF; LH at the same address -> 0xFFFF80FF; LW addr 0x1000 -> 0x80FF1234.
- SB addr 0x2001, wdata 0x000000AB -> dmem_req_data=0x0000AB00, typ=0, fcn=1, addr=0x2001; core_resp_valid with rdata=0.
- LW addr 0x1002 -> no dmem_req_valid ever; core_resp_valid with misaligned=1 one cycle after accept. SH addr 0x3001 -> same behaviour.
- dmem_req_ready low for 3 cycles, then high with resp_valid delayed 2 more cycles:
  - valid and fields remain stable through the stall; valid drops after the handshake.
  - Response is captured correctly; the timeout counter reads 5 at capture.
- TIMEOUT=4 with dmem_resp_valid stuck at 0 -> core_resp_timeout=1 on the 5th cycle after accept. Separately, assert rst_n=0 while in RESP -> immediate IDLE, no core_resp_valid, core_req_ready=1 after release.
